int_arbiter: RTL and testbench

Parametrised trap and interrupt controller for the core's commit stage. It latches NUM_IRQ external interrupt lines into pending bits and masks them with per-channel enables and the global MIE bit. It arbitrates them by fixed priority against synchronous ECALL/EBREAK and MRET, then sequences the machine CSR updates (mepc, mstatus, mcause) one per cycle. It finally issues a redirect to the pipeline, with optional vectored trap addressing.

---
 rtl/int_pkg.sv | 40 ++++
 rtl/irq_pending.sv | 58 +++++
 rtl/int_arbiter.sv | 146 ++++++++++++++
 tb/tb_int_arbiter.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/int_pkg.sv
// rtl/int_pkg.sv - shared CSR addresses, cause codes, mstatus bits and trap FSM states
package int_pkg;

    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    localparam logic [31:0] CAUSE_ECALL  = 32'h0000_000B;
    localparam logic [31:0] CAUSE_EBREAK = 32'h0000_0003;

    localparam int MIE_BIT  = 3;
    localparam int MPIE_BIT = 7;

    typedef enum logic [6:0] {
        S_IDLE         = 7'b000_0001,
        S_MEPC         = 7'b000_0010,
        S_MSTATUS      = 7'b000_0100,
        S_MCAUSE       = 7'b000_1000,
        S_ASSERT       = 7'b001_0000,
        S_MRET_MSTATUS = 7'b010_0000,
        S_MRET_ASSERT  = 7'b100_0000
    } int_state_e;

    function automatic logic [31:0] trap_mstatus(input logic [31:0] ms);
        logic [31:0] r;
        r           = ms;
        r[MPIE_BIT] = ms[MIE_BIT];
        r[MIE_BIT]  = 1'b0;
        return r;
    endfunction

    function automatic logic [31:0] mret_mstatus(input logic [31:0] ms);
        logic [31:0] r;
        r           = ms;
        r[MIE_BIT]  = ms[MPIE_BIT];
        r[MPIE_BIT] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/irq_pending.sv
// rtl/irq_pending.sv - interrupt edge detect, pending latch, enable mask and priority encoder
module irq_pending #(
    parameter int NUM_IRQ   = 8,
    parameter bit EDGE_TRIG = 1'b1,
    parameter int ID_W      = 3
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [NUM_IRQ-1:0] irq_i,
    input  logic [NUM_IRQ-1:0] irq_en_i,
    input  logic               mie_i,
    input  logic               clr_i,
    input  logic [ID_W-1:0]    clr_id_i,
    output logic [NUM_IRQ-1:0] pend_o,
    output logic               any_o,
    output logic [ID_W-1:0]    id_o
);

    logic [NUM_IRQ-1:0] clr_mask;
    logic [NUM_IRQ-1:0] elig;

    always_comb begin
        clr_mask = '0;
        for (int k = 0; k < NUM_IRQ; k++) begin
            clr_mask[k] = clr_i && (clr_id_i == ID_W'(k));
        end
    end

    if (EDGE_TRIG) begin : g_edge
        logic [NUM_IRQ-1:0] irq_q;
        logic [NUM_IRQ-1:0] pend_q;

        // A new rising edge in the same cycle as the clear keeps the bit set.
        always_ff @(posedge clk) begin
            if (!rstn) begin
                irq_q  <= '0;
                pend_q <= '0;
            end else begin
                irq_q  <= irq_i;
                pend_q <= (pend_q & ~clr_mask) | (irq_i & ~irq_q);
            end
        end
        assign pend_o = pend_q;
    end else begin : g_level
        assign pend_o = irq_i;
    end

    assign elig = pend_o & irq_en_i & {NUM_IRQ{mie_i}};

    always_comb begin
        any_o = |elig;
        id_o  = '0;
        for (int k = NUM_IRQ - 1; k >= 0; k--) begin
            if (elig[k]) id_o = ID_W'(k);
        end
    end

endmodule

// File: rtl/int_arbiter.sv
// rtl/int_arbiter.sv - trap/interrupt arbiter sequencing mepc, mstatus, mcause and the redirect
module int_arbiter
    import int_pkg::*;
#(
    parameter int NUM_IRQ    = 8,
    parameter int CAUSE_BASE = 16,
    parameter bit EDGE_TRIG  = 1'b1,
    parameter int ID_W       = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [NUM_IRQ-1:0] irq_i,
    input  logic [NUM_IRQ-1:0] irq_en_i,
    input  logic               ecall_i,
    input  logic               ebreak_i,
    input  logic               mret_i,
    input  logic [31:0]        inst_addr_i,
    input  logic               jump_flag_i,
    input  logic [31:0]        jump_addr_i,
    input  logic [31:0]        csr_mtvec_i,
    input  logic [31:0]        csr_mepc_i,
    input  logic [31:0]        csr_mstatus_i,
    output logic               hold_o,
    output logic               csr_we_o,
    output logic [11:0]        csr_waddr_o,
    output logic [31:0]        csr_wdata_o,
    output logic               int_assert_o,
    output logic [31:0]        int_addr_o,
    output logic [ID_W-1:0]    int_id_o,
    output logic [NUM_IRQ-1:0] mip_o
);

    int_state_e      state_q;
    logic [31:0]     cause_q;
    logic            async_q;
    logic [ID_W-1:0] int_id_q;
    logic            csr_we_q;
    logic [11:0]     csr_waddr_q;
    logic [31:0]     csr_wdata_q;
    logic            int_assert_q;
    logic [31:0]     int_addr_q;

    logic            irq_any;
    logic [ID_W-1:0] irq_id;
    logic            sync_evt;
    logic            take_irq;
    logic [31:0]     ret_addr;
    logic [31:0]     irq_cause;
    logic [31:0]     trap_base;
    logic [31:0]     vec_addr;

    irq_pending #(
        .NUM_IRQ  (NUM_IRQ),
        .EDGE_TRIG(EDGE_TRIG),
        .ID_W     (ID_W)
    ) u_pending (
        .clk     (clk),
        .rstn    (rstn),
        .irq_i   (irq_i),
        .irq_en_i(irq_en_i),
        .mie_i   (csr_mstatus_i[MIE_BIT]),
        .clr_i   (take_irq),
        .clr_id_i(irq_id),
        .pend_o  (mip_o),
        .any_o   (irq_any),
        .id_o    (irq_id)
    );

    assign sync_evt  = ecall_i || ebreak_i;
    assign take_irq  = (state_q == S_IDLE) && !sync_evt && irq_any;
    assign ret_addr  = jump_flag_i ? jump_addr_i : (inst_addr_i + (sync_evt ? 32'd4 : 32'd0));
    assign irq_cause = {1'b1, 31'(CAUSE_BASE) + 31'(irq_id)};
    assign trap_base = {csr_mtvec_i[31:2], 2'b00};
    // The low cause bits hold the exception code, so code*4 is a shift.
    assign vec_addr  = trap_base + {cause_q[29:0], 2'b00};
    assign hold_o    = (state_q != S_IDLE) || sync_evt || irq_any || mret_i;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q      <= S_IDLE;
            cause_q      <= '0;
            async_q      <= 1'b0;
            int_id_q     <= '0;
            csr_we_q     <= 1'b0;
            csr_waddr_q  <= '0;
            csr_wdata_q  <= '0;
            int_assert_q <= 1'b0;
            int_addr_q   <= '0;
        end else begin
            csr_we_q     <= 1'b0;
            csr_waddr_q  <= '0;
            csr_wdata_q  <= '0;
            int_assert_q <= 1'b0;
            int_addr_q   <= '0;
            unique case (state_q)
                S_IDLE: begin
                    if (sync_evt || irq_any) begin
                        state_q     <= S_MEPC;
                        csr_we_q    <= 1'b1;
                        csr_waddr_q <= CSR_MEPC;
                        csr_wdata_q <= ret_addr;
                        async_q     <= !sync_evt;
                        cause_q     <= ecall_i ? CAUSE_ECALL : (ebreak_i ? CAUSE_EBREAK : irq_cause);
                        if (!sync_evt) int_id_q <= irq_id;
                    end else if (mret_i) begin
                        state_q     <= S_MRET_MSTATUS;
                        csr_we_q    <= 1'b1;
                        csr_waddr_q <= CSR_MSTATUS;
                        csr_wdata_q <= mret_mstatus(csr_mstatus_i);
                    end
                end
                S_MEPC: begin
                    state_q     <= S_MSTATUS;
                    csr_we_q    <= 1'b1;
                    csr_waddr_q <= CSR_MSTATUS;
                    csr_wdata_q <= trap_mstatus(csr_mstatus_i);
                end
                S_MSTATUS: begin
                    state_q     <= S_MCAUSE;
                    csr_we_q    <= 1'b1;
                    csr_waddr_q <= CSR_MCAUSE;
                    csr_wdata_q <= cause_q;
                end
                S_MCAUSE: begin
                    state_q      <= S_ASSERT;
                    int_assert_q <= 1'b1;
                    int_addr_q   <= (async_q && csr_mtvec_i[1:0] == 2'b01) ? vec_addr : trap_base;
                end
                S_MRET_MSTATUS: begin
                    state_q      <= S_MRET_ASSERT;
                    int_assert_q <= 1'b1;
                    int_addr_q   <= csr_mepc_i;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign csr_we_o     = csr_we_q;
    assign csr_waddr_o  = csr_waddr_q;
    assign csr_wdata_o  = csr_wdata_q;
    assign int_assert_o = int_assert_q;
    assign int_addr_o   = int_addr_q;
    assign int_id_o     = int_id_q;

endmodule

// File: tb/tb_int_arbiter.sv
// tb/tb_int_arbiter.sv - randomized and directed check of int_arbiter against a sequence-queue model
module tb_int_arbiter;

    localparam int N  = 8;
    localparam int CB = 16;
    localparam int IW = 3;

    logic          clk = 1'b0;
    logic          rstn;
    logic [N-1:0]  irq, irq_en;
    logic          ecall, ebreak, mret, jump;
    logic [31:0]   inst, jaddr, mtvec, mepc, mstatus;
    logic          hold_o, csr_we_o, int_assert_o;
    logic [11:0]   csr_waddr_o;
    logic [31:0]   csr_wdata_o, int_addr_o;
    logic [IW-1:0] int_id_o;
    logic [N-1:0]  mip_o;

    always #5 clk = ~clk;

    int_arbiter #(.NUM_IRQ(N), .CAUSE_BASE(CB), .EDGE_TRIG(1'b1), .ID_W(IW)) dut (
        .clk(clk), .rstn(rstn), .irq_i(irq), .irq_en_i(irq_en),
        .ecall_i(ecall), .ebreak_i(ebreak), .mret_i(mret),
        .inst_addr_i(inst), .jump_flag_i(jump), .jump_addr_i(jaddr),
        .csr_mtvec_i(mtvec), .csr_mepc_i(mepc), .csr_mstatus_i(mstatus),
        .hold_o(hold_o), .csr_we_o(csr_we_o), .csr_waddr_o(csr_waddr_o),
        .csr_wdata_o(csr_wdata_o), .int_assert_o(int_assert_o),
        .int_addr_o(int_addr_o), .int_id_o(int_id_o), .mip_o(mip_o)
    );

    typedef struct packed {
        logic        we;
        logic [11:0] wa;
        logic [31:0] wd;
        logic        as;
        logic [31:0] ia;
    } exp_t;

    exp_t          q[$];
    logic [N-1:0]  m_pend, m_prev;
    logic [IW-1:0] m_id;
    logic          eff_pend, eff_ready, eff_set_mepc;
    logic [31:0]   eff_ms, eff_mepc;
    int            total = 0;
    int            bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // One cycle: compare outputs with the model, then advance the model across the clock edge.
    task automatic step();
        exp_t        e;
        logic [N-1:0] elig, clr;
        logic        busy, evt, sync;
        int          k;
        logic [31:0] ret, cause, ms1, base, tgt;
        #1;
        busy = (q.size() != 0);
        elig = m_pend & irq_en & {N{mstatus[3]}};
        k = -1;
        for (int i = N - 1; i >= 0; i--) if (elig[i]) k = i;
        evt = ecall || ebreak || (k >= 0) || mret;
        e = busy ? q[0] : '0;
        chk("hold", hold_o, busy || evt);
        chk("csr_we", csr_we_o, e.we);
        chk("csr_waddr", csr_waddr_o, e.wa);
        chk("csr_wdata", csr_wdata_o, e.wd);
        chk("int_assert", int_assert_o, e.as);
        chk("int_addr", int_addr_o, e.ia);
        chk("mip", mip_o, m_pend);
        chk("int_id", int_id_o, m_id);
        if (!rstn) begin
            q.delete();
            m_pend = '0; m_prev = '0; m_id = '0; eff_pend = 1'b0;
        end else begin
            clr = '0;
            if (busy) begin
                void'(q.pop_front());
                if (q.size() == 0 && eff_pend) begin eff_ready = 1'b1; eff_pend = 1'b0; end
            end else if (ecall || ebreak || k >= 0) begin
                sync  = ecall || ebreak;
                ret   = jump ? jaddr : (sync ? inst + 32'd4 : inst);
                cause = ecall ? 32'hB : (ebreak ? 32'h3 : (32'h8000_0000 | 32'(CB + k)));
                ms1   = mstatus; ms1[7] = mstatus[3]; ms1[3] = 1'b0;
                base  = {mtvec[31:2], 2'b00};
                tgt   = (!sync && mtvec[1:0] == 2'b01) ? base + 32'(4 * (CB + k)) : base;
                q.push_back('{1'b1, 12'h341, ret, 1'b0, 32'h0});
                q.push_back('{1'b1, 12'h300, ms1, 1'b0, 32'h0});
                q.push_back('{1'b1, 12'h342, cause, 1'b0, 32'h0});
                q.push_back('{1'b0, 12'h000, 32'h0, 1'b1, tgt});
                if (!sync) begin clr[k] = 1'b1; m_id = k[IW-1:0]; end
                eff_ms = ms1; eff_mepc = ret; eff_set_mepc = 1'b1; eff_pend = 1'b1;
            end else if (mret) begin
                ms1 = mstatus; ms1[3] = mstatus[7]; ms1[7] = 1'b1;
                q.push_back('{1'b1, 12'h300, ms1, 1'b0, 32'h0});
                q.push_back('{1'b0, 12'h000, 32'h0, 1'b1, mepc});
                eff_ms = ms1; eff_set_mepc = 1'b0; eff_pend = 1'b1;
            end
            m_pend = (m_pend & ~clr) | (irq & ~m_prev);
            m_prev = irq;
        end
        @(posedge clk);
        @(negedge clk);
        if (eff_ready) begin
            mstatus = eff_ms;
            if (eff_set_mepc) mepc = eff_mepc;
            eff_ready = 1'b0;
        end
    endtask

    initial begin
        logic [31:0] tmp;
        rstn = 1'b0; irq = '0; irq_en = '0; ecall = 0; ebreak = 0; mret = 0; jump = 0;
        inst = '0; jaddr = '0; mtvec = '0; mepc = '0; mstatus = '0;
        m_pend = '0; m_prev = '0; m_id = '0; eff_pend = 0; eff_ready = 0; eff_set_mepc = 0;
        eff_ms = '0; eff_mepc = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_we", csr_we_o, 0);
        chk("rst_assert", int_assert_o, 0);
        chk("rst_mip", mip_o, 0);
        chk("rst_id", int_id_o, 0);
        rstn = 1'b1;
        step();

        // ECALL with plain mtvec
        inst = 32'h100; mtvec = 32'h200; mstatus = 32'h8; ecall = 1;
        #1 chk("ecall_hold0", hold_o, 1);
        step(); ecall = 0;
        chk("ecall_mepc_a", csr_waddr_o, 12'h341); chk("ecall_mepc_d", csr_wdata_o, 32'h104);
        step();
        chk("ecall_ms_a", csr_waddr_o, 12'h300); chk("ecall_ms_d", csr_wdata_o, 32'h80);
        step();
        chk("ecall_cause_a", csr_waddr_o, 12'h342); chk("ecall_cause_d", csr_wdata_o, 32'hB);
        step();
        chk("ecall_assert", int_assert_o, 1); chk("ecall_addr", int_addr_o, 32'h200);
        step();
        #1 chk("ecall_hold5", hold_o, 0);

        // vectored irq 5
        mstatus = 32'h8; irq_en = 8'hFF; mtvec = 32'h201; irq = 8'h20;
        step(); irq = 8'h00;
        chk("irq5_mip_set", mip_o[5], 1);
        step();
        chk("irq5_mip_clr", mip_o[5], 0);
        repeat (2) step();
        chk("irq5_cause", csr_wdata_o, 32'h8000_0015);
        step();
        chk("irq5_addr", int_addr_o, 32'h254); chk("irq5_id", int_id_o, 5);
        step();

        // channels 2 and 6 together, then MRET, then channel 6
        mstatus = 32'h8; mtvec = 32'h200; irq = 8'h44;
        step(); irq = 8'h00;
        step();
        chk("ch2_id", int_id_o, 2);
        repeat (4) step();
        chk("ch6_still_pend", mip_o[6], 1);
        #1 chk("ch6_blocked", hold_o, 0);
        mepc = 32'h300; mret = 1;
        step(); mret = 0;
        chk("mret_ms_a", csr_waddr_o, 12'h300); chk("mret_ms_d", csr_wdata_o, 32'h88);
        step();
        chk("mret_assert", int_assert_o, 1); chk("mret_addr", int_addr_o, 32'h300);
        step();
        #1 chk("ch6_hold", hold_o, 1);
        step();
        chk("ch6_id", int_id_o, 6); chk("ch6_mip_clr", mip_o[6], 0);
        repeat (4) step();

        // ecall beats an eligible irq 0 and uses the jump target
        mstatus = 32'h8; irq = 8'h01;
        step(); irq = 8'h00; ecall = 1; jump = 1; jaddr = 32'h400;
        step(); ecall = 0; jump = 0;
        chk("ecall_jump_mepc", csr_wdata_o, 32'h400); chk("irq0_kept", mip_o[0], 1);
        repeat (2) step();
        chk("ecall_jump_cause", csr_wdata_o, 32'hB);
        repeat (2) step();

        // masked by MIE, then by the channel enable
        irq = 8'h08; mstatus = 32'h0;
        step(); irq = 8'h00;
        #1 chk("mie0_mip3", mip_o[3], 1); chk("mie0_hold", hold_o, 0);
        step();
        mstatus = 32'h8; irq_en = 8'h00;
        #1 chk("en0_hold", hold_o, 0);
        step();

        // reset while in MSTATUS aborts the sequence
        ecall = 1;
        step(); ecall = 0;
        step();
        chk("abort_in_ms", csr_waddr_o, 12'h300);
        rstn = 0;
        step(); rstn = 1;
        chk("abort_we", csr_we_o, 0); chk("abort_wd", csr_wdata_o, 0);
        chk("abort_assert", int_assert_o, 0); chk("abort_id", int_id_o, 0);
        chk("abort_mip", mip_o, 0);
        step();
        chk("abort_no_mcause", csr_we_o, 0);

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < N; b++) if ($urandom_range(15) == 0) irq[b] = ~irq[b];
            ecall  = ($urandom_range(39) == 0);
            ebreak = ($urandom_range(39) == 0);
            mret   = ($urandom_range(19) == 0);
            jump   = ($urandom_range(3) == 0);
            inst   = $urandom;
            jaddr  = $urandom;
            if (q.size() == 0) begin
                if ($urandom_range(7) == 0) mstatus[3] = 1'b1;
                if ($urandom_range(49) == 0) irq_en = N'($urandom);
                if ($urandom_range(29) == 0) begin
                    tmp = $urandom; tmp[1:0] = 2'($urandom_range(1)); mtvec = tmp;
                end
                if ($urandom_range(29) == 0) mepc = $urandom;
            end
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
